regfile_port_arbiter: RTL and testbench

- Sits directly upstream of the 32x32 register file and owns its single shared port: the ReadWriteEn select (1 = read, 0 = write), two read addresses, one write address and write data.
- Accepts write-back requests into a small write FIFO and dual-operand read requests from decode, and decides every cycle whether the register file reads or writes.
- Enforces read-after-write ordering and write forward progress.
- Returns read data one cycle after a read is accepted.

---
 rtl/regfile_port_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Arbitrates the single shared register-file port between buffered write-back
// requests and dual-operand decode reads, keeping read-after-write order.
module regfile_port_arbiter #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MAX_DEFER = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   input  logic [4:0]  wr_addr_i,
   input  logic [31:0] wr_data_i,
   input  logic        rd_valid_i,
   output logic        rd_ready_o,
   input  logic [4:0]  rd_addr1_i,
   input  logic [4:0]  rd_addr2_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data1_o,
   output logic [31:0] rsp_data2_o,
   output logic        rf_rw_en_o,
   output logic [4:0]  rf_raddr1_o,
   output logic [4:0]  rf_raddr2_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   input  logic [31:0] rf_rdata1_i,
   input  logic [31:0] rf_rdata2_i
);

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned FW = $clog2(MAX_DEFER + 1);

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic [FW-1:0]    defer_q, defer_d;
   logic             rsp_valid_q;

   logic hazard, fifo_empty, fifo_full, force_wr, read_fire, drain, push;

   // A read must wait while any buffered write targets one of its operands
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (addr_q[i] == rd_addr1_i || addr_q[i] == rd_addr2_i)) begin
            hazard = 1'b1;
         end
      end
   end

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign force_wr   = !fifo_empty && (fifo_full || defer_q == FW'(MAX_DEFER));

   assign rd_ready_o = !rst_i && !hazard && !force_wr;
   assign read_fire  = rd_valid_i && rd_ready_o;
   assign drain      = !rst_i && !fifo_empty && !read_fire;
   assign wr_ready_o = !rst_i && !fifo_full;
   assign push       = wr_valid_i && wr_ready_o;

   assign rf_rw_en_o  = !drain;
   assign rf_raddr1_o = rd_addr1_i;
   assign rf_raddr2_o = rd_addr2_i;
   assign rf_waddr_o  = addr_q[rptr_q];
   assign rf_wdata_o  = data_q[rptr_q];

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data1_o = rf_rdata1_i;
   assign rsp_data2_o = rf_rdata2_i;

   // Occupancy and read-deferral bookkeeping
   always_comb begin
      count_d = count_q;
      defer_d = defer_q;
      if (push && !drain) begin
         count_d = count_q + CW'(1);
      end else if (drain && !push) begin
         count_d = count_q - CW'(1);
      end
      if (fifo_empty || drain) begin
         defer_d = '0;
      end else if (read_fire && defer_q != FW'(MAX_DEFER)) begin
         defer_d = defer_q + FW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         vld_q       <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         defer_q     <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         if (push) begin
            addr_q[wptr_q] <= wr_addr_i;
            data_q[wptr_q] <= wr_data_i;
            vld_q[wptr_q]  <= 1'b1;
            wptr_q         <= wptr_q + PW'(1);
         end
         if (drain) begin
            vld_q[rptr_q] <= 1'b0;
            rptr_q        <= rptr_q + PW'(1);
         end
         count_q     <= count_d;
         defer_q     <= defer_d;
         rsp_valid_q <= read_fire;
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: a register-file model on the port, directed
// scenarios, and a per-cycle scoreboard driven by a program-order reference.
module tb_regfile_port_arbiter;

   localparam int unsigned DEPTH     = 4;
   localparam int unsigned MAX_DEFER = 3;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rf_rw_en;
   logic [4:0]  wr_addr, rd_addr1, rd_addr2, rf_raddr1, rf_raddr2, rf_waddr;
   logic [31:0] wr_data, rsp_data1, rsp_data2, rf_wdata, rf_rdata1, rf_rdata2;

   int checks = 0;
   int errors = 0;

   regfile_port_arbiter #(.DEPTH(DEPTH), .MAX_DEFER(MAX_DEFER)) dut (
      .clk_i(clk), .rst_i(rst),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
      .rsp_valid_o(rsp_valid), .rsp_data1_o(rsp_data1), .rsp_data2_o(rsp_data2),
      .rf_rw_en_o(rf_rw_en), .rf_raddr1_o(rf_raddr1), .rf_raddr2_o(rf_raddr2),
      .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
      .rf_rdata1_i(rf_rdata1), .rf_rdata2_i(rf_rdata2)
   );

   always #5 clk = ~clk;

   // Register file: writes whenever rw_en=0, registered reads otherwise
   logic [31:0] mem [32];
   bit          rf_seeded = 1'b0;
   always @(posedge clk) begin
      if (!rf_seeded) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
         rf_seeded <= 1'b1;
      end else if (rf_rw_en === 1'b0) begin
         mem[rf_waddr] <= rf_wdata;
      end else begin
         rf_rdata1 <= mem[rf_raddr1];
         rf_rdata2 <= mem[rf_raddr2];
      end
   end

   // Reference: arch = program-order register view, rfm = committed RF view
   logic [31:0] arch [32];
   logic [31:0] rfm  [32];
   wr_t         wq [$];
   int          defer = 0;
   bit          sb_seeded = 1'b0;
   bit          rsp_pend = 1'b0;
   logic [31:0] exp1, exp2;
   bit          sb_hz, sb_force, sb_rr, sb_fire, sb_drn;
   int          sb_n;

   always @(negedge clk) begin
      if (!sb_seeded) begin
         for (int i = 0; i < 32; i++) rfm[i] = 32'h1000_0000 + 32'(i);
         sb_seeded = 1'b1;
      end
      if (rst) begin
         checks++;
         if (rd_ready !== 1'b0 || wr_ready !== 1'b0 || rf_rw_en !== 1'b1) begin
            errors++;
            $display("FAIL sb_reset rd_ready=%b wr_ready=%b rf_rw_en=%b required 0 0 1",
                     rd_ready, wr_ready, rf_rw_en);
         end
         wq.delete();
         defer    = 0;
         rsp_pend = 1'b0;
         arch     = rfm;
      end else begin
         sb_n  = wq.size();
         sb_hz = 1'b0;
         foreach (wq[i]) if (wq[i].a == rd_addr1 || wq[i].a == rd_addr2) sb_hz = 1'b1;
         sb_force = sb_n > 0 && (sb_n == DEPTH || defer == MAX_DEFER);
         sb_rr    = !sb_hz && !sb_force;
         sb_fire  = rd_valid && sb_rr;
         sb_drn   = sb_n > 0 && !sb_fire;
         checks++;
         if (rd_ready !== sb_rr || wr_ready !== (sb_n < DEPTH) || rf_rw_en !== !sb_drn) begin
            errors++;
            $display("FAIL sb_ctrl t=%0t rd_ready=%b wr_ready=%b rf_rw_en=%b required %b %b %b",
                     $time, rd_ready, wr_ready, rf_rw_en, sb_rr, sb_n < DEPTH, !sb_drn);
         end
         if (sb_drn) begin
            checks++;
            if (rf_waddr !== wq[0].a || rf_wdata !== wq[0].d) begin
               errors++;
               $display("FAIL sb_drain t=%0t waddr=%0d wdata=%h required %0d %h",
                        $time, rf_waddr, rf_wdata, wq[0].a, wq[0].d);
            end
         end
         if (sb_fire) begin
            checks++;
            if (rf_raddr1 !== rd_addr1 || rf_raddr2 !== rd_addr2) begin
               errors++;
               $display("FAIL sb_raddr t=%0t raddr=%0d,%0d required %0d,%0d",
                        $time, rf_raddr1, rf_raddr2, rd_addr1, rd_addr2);
            end
         end
         checks++;
         if (rsp_valid !== rsp_pend) begin
            errors++;
            $display("FAIL sb_rsp_valid t=%0t got=%b required %b", $time, rsp_valid, rsp_pend);
         end else if (rsp_pend && (rsp_data1 !== exp1 || rsp_data2 !== exp2)) begin
            errors++;
            $display("FAIL sb_rsp_data t=%0t got=%h,%h required %h,%h",
                     $time, rsp_data1, rsp_data2, exp1, exp2);
         end
         rsp_pend = sb_fire;
         if (sb_fire) begin
            exp1 = arch[rd_addr1];
            exp2 = arch[rd_addr2];
         end
         if (sb_n == 0 || sb_drn) defer = 0;
         else if (sb_fire && defer < MAX_DEFER) defer++;
         if (sb_drn) begin
            rfm[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
         end
         if (wr_valid && sb_n < DEPTH) begin
            wq.push_back(wr_t'{a: wr_addr, d: wr_data});
            arch[wr_addr] = wr_data;
         end
      end
   end

   // Advance one cycle, drive inputs just after the edge, return at mid-cycle
   task automatic cyc(input logic r, input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rv, input logic [4:0] a1, input logic [4:0] a2);
      @(posedge clk);
      #1;
      rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr1 = a1; rd_addr2 = a2;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      checks++;
      if (rsp_valid !== 1'b0 || $isunknown({rf_waddr, rf_wdata})) begin
         errors++;
         $display("FAIL reset_outputs rsp_valid=%b waddr=%b wdata=%h required 0 and known",
                  rsp_valid, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_write_read();
      int n = 0;
      cyc(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd0);
      if (rf_rw_en === 1'b0) n++;
      for (int i = 0; i < 2; i++) begin
         idle(1);
         if (rf_rw_en === 1'b0) n++;
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL wr_single_drain write_cycles=%0d required 1", n);
      end
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
      idle(1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data1 !== 32'h1234_5678 || rsp_data2 !== 32'h1000_0000) begin
         errors++;
         $display("FAIL wr_readback valid=%b data=%h,%h required 1 12345678,10000000",
                  rsp_valid, rsp_data1, rsp_data2);
      end
   endtask

   task automatic test_raw_hazard();
      cyc(1'b0, 1'b1, 5'd15, 32'hABCD_ABCD, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 5'd5);
      checks++;
      if (rd_ready !== 1'b0 || rf_rw_en !== 1'b0 || rf_waddr !== 5'd15) begin
         errors++;
         $display("FAIL raw_block rd_ready=%b rw_en=%b waddr=%0d required 0 0 15",
                  rd_ready, rf_rw_en, rf_waddr);
      end
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 5'd5);
      checks++;
      if (rd_ready !== 1'b1) begin
         errors++;
         $display("FAIL raw_accept rd_ready=%b required 1", rd_ready);
      end
      idle(1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data1 !== 32'hABCD_ABCD || rsp_data2 !== 32'h1234_5678) begin
         errors++;
         $display("FAIL raw_data valid=%b data=%h,%h required 1 abcdabcd,12345678",
                  rsp_valid, rsp_data1, rsp_data2);
      end
   endtask

   task automatic test_fifo_full();
      logic [4:0] order [4];
      // Reads of reg 0 hold off draining until the FIFO fills
      for (int r = 1; r <= 4; r++)
         cyc(1'b0, 1'b1, 5'(r), 32'h11 * 32'(r), 1'b1, 5'd0, 5'd0);
      cyc(1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd0, 5'd0);
      checks++;
      if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready wr_ready=%b rd_ready=%b required 0 0", wr_ready, rd_ready);
      end
      order[0] = (rf_rw_en === 1'b0) ? rf_waddr : 5'd31;
      for (int i = 1; i < 4; i++) begin
         idle(1);
         order[i] = (rf_rw_en === 1'b0) ? rf_waddr : 5'd31;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (order[i] !== 5'(i + 1)) begin
            errors++;
            $display("FAIL full_drain_order slot=%0d got=%0d required %0d", i, order[i], i + 1);
         end
      end
      for (int r = 1; r <= 4; r++) begin
         cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 5'(r));
         idle(1);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_data1 !== 32'h11 * 32'(r)) begin
            errors++;
            $display("FAIL full_readback reg=%0d valid=%b data=%h required 1 %h",
                     r, rsp_valid, rsp_data1, 32'h11 * 32'(r));
         end
      end
   endtask

   task automatic test_defer();
      logic [5:0] seen, want;
      want = 6'b110111;
      cyc(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
         seen[i] = rd_ready;
         if (i == 3) begin
            checks++;
            if (rf_rw_en !== 1'b0 || rf_waddr !== 5'd7) begin
               errors++;
               $display("FAIL defer_forced rw_en=%b waddr=%0d required 0 7", rf_rw_en, rf_waddr);
            end
         end
      end
      checks++;
      if (seen !== want) begin
         errors++;
         $display("FAIL defer_pattern got=%b required %b", seen, want);
      end
      idle(1);
   endtask

   task automatic test_same_cycle();
      cyc(1'b0, 1'b1, 5'd9, 32'hBEEF, 1'b0, 5'd0, 5'd0);
      idle(2);
      cyc(1'b0, 1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd9, 5'd9);
      checks++;
      if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL same_accept rd_ready=%b wr_ready=%b required 1 1", rd_ready, wr_ready);
      end
      idle(1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data1 !== 32'hBEEF || rsp_data2 !== 32'hBEEF) begin
         errors++;
         $display("FAIL same_old valid=%b data=%h,%h required 1 beef,beef",
                  rsp_valid, rsp_data1, rsp_data2);
      end
      idle(1);
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9);
      idle(1);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data1 !== 32'hDEAD) begin
         errors++;
         $display("FAIL same_new valid=%b data=%h required 1 dead", rsp_valid, rsp_data1);
      end
   endtask

   task automatic test_reset_midflight();
      int n = 0;
      cyc(1'b0, 1'b1, 5'd20, 32'hA0, 1'b1, 5'd0, 5'd0);
      cyc(1'b0, 1'b1, 5'd21, 32'hA1, 1'b1, 5'd0, 5'd0);
      cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      if (rf_rw_en === 1'b0) n++;
      idle(1);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_rsp_cleared got=%b required 0", rsp_valid);
      end
      if (rf_rw_en === 1'b0) n++;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         if (rf_rw_en === 1'b0) n++;
      end
      checks++;
      if (n != 0 || mem[20] !== 32'h1000_0014 || mem[21] !== 32'h1000_0015) begin
         errors++;
         $display("FAIL mid_discard writes=%0d reg20=%h reg21=%h required 0 10000014 10000015",
                  n, mem[20], mem[21]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             $urandom, 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)));
      end
      idle(DEPTH + 2);
      for (int r = 0; r < 32; r++) begin
         checks++;
         if (mem[r] !== rfm[r]) begin
            errors++;
            $display("FAIL random_rf_contents reg=%0d got=%h required %h", r, mem[r], rfm[r]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0;
      test_reset();
      test_write_read();
      test_raw_hazard();
      test_fifo_full();
      test_defer();
      test_same_cycle();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
